// File: rtl/ctrl_state_sequencer_if.sv
// rtl/ctrl_state_sequencer_if.sv - control/status bundle between the datapath and the state sequencer
interface ctrl_state_sequencer_if #(
  parameter int STATE_W = 7,
  parameter int CNT_W   = 16
);
  logic [31:0]        Instruction;
  logic               MOC;
  logic               Cond;
  logic               Stall;
  logic [STATE_W-1:0] State_Sel;
  logic               Retire;
  logic               Illegal_Op;
  logic               Bus_Err;
  logic [CNT_W-1:0]   Instr_Count;

  // Datapath / memory side: drives IR, MOC, compare result and stall
  modport master (
    output Instruction, MOC, Cond, Stall,
    input  State_Sel, Retire, Illegal_Op, Bus_Err, Instr_Count
  );

  // Sequencer side
  modport slave (
    input  Instruction, MOC, Cond, Stall,
    output State_Sel, Retire, Illegal_Op, Bus_Err, Instr_Count
  );
endinterface

// File: rtl/ctrl_state_sequencer.sv
// rtl/ctrl_state_sequencer.sv - registered multi-cycle MIPS control-state sequencer
module ctrl_state_sequencer #(
  parameter int STATE_W   = 7,
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  ctrl_state_sequencer_if.slave bus
);

  // State numbering matches the combinational control encoder
  typedef enum logic [6:0] {
    S_FETCH0     = 7'd0,
    S_FETCH1     = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_FETCH3     = 7'd3,
    S_DECODE     = 7'd4,
    S_ADDU       = 7'd6,
    S_STORE      = 7'd7,
    S_STORE_WAIT = 7'd8,
    S_BEQ        = 7'd11,
    S_BEQ_TAKEN  = 7'd12,
    S_LOAD       = 7'd13,
    S_LOAD_WAIT  = 7'd14,
    S_LOAD_WB    = 7'd15,
    S_SUBU       = 7'd17,
    S_ADDIU      = 7'd18,
    S_SLTU       = 7'd19,
    S_SLTIU      = 7'd20,
    S_CLO        = 7'd21,
    S_CLZ        = 7'd22,
    S_AND        = 7'd23,
    S_ANDI       = 7'd24,
    S_OR         = 7'd25,
    S_ORI        = 7'd26,
    S_ERROR      = 7'd126,
    S_ILLEGAL    = 7'd127
  } state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 retire_q, retire_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;
  logic                 wait_expired;

  // Only opcode and funct take part in decode; the register/immediate fields are don't-care here
  logic                 unused_instr_bits;
  assign unused_instr_bits = ^bus.Instruction[25:6];

  assign wait_expired = (wait_q == {TIMEOUT_W{1'b1}});

  // Map opcode/funct to the execute entry state; anything unrecognised goes to ILLEGAL
  function automatic state_t decode(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = S_ILLEGAL;
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   s = S_ADDU;
          6'h23:   s = S_SUBU;
          6'h2B:   s = S_SLTU;
          6'h24:   s = S_AND;
          6'h25:   s = S_OR;
          default: s = S_ILLEGAL;
        endcase
      end
      6'h1C: begin
        case (fn)
          6'h21:   s = S_CLO;
          6'h20:   s = S_CLZ;
          default: s = S_ILLEGAL;
        endcase
      end
      6'h09:                      s = S_ADDIU;
      6'h0B:                      s = S_SLTIU;
      6'h0C:                      s = S_ANDI;
      6'h0D:                      s = S_ORI;
      6'h04:                      s = S_BEQ;
      6'h20, 6'h21, 6'h23,
      6'h24, 6'h25:               s = S_LOAD;
      6'h28, 6'h29, 6'h2B:        s = S_STORE;
      default:                    s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  // Next-state, wait counter, retire and sticky flag computation; Stall freezes everything
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    count_d   = count_q;
    retire_d  = 1'b0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if (!bus.Stall) begin
      case (state_q)
        S_FETCH0: state_d = S_FETCH1;
        S_FETCH1: begin
          state_d = S_FETCH_WAIT;
          wait_d  = '0;
        end
        S_FETCH_WAIT: begin
          if (bus.MOC) begin
            state_d = S_FETCH3;
          end else if (wait_expired) begin
            state_d   = S_ERROR;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + TIMEOUT_W'(1);
          end
        end
        S_FETCH3: state_d = S_DECODE;
        S_DECODE: state_d = decode(bus.Instruction[31:26], bus.Instruction[5:0]);
        S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ,
        S_AND, S_ANDI, S_OR, S_ORI: begin
          state_d  = S_FETCH1;
          retire_d = 1'b1;
        end
        S_STORE: begin
          state_d = S_STORE_WAIT;
          wait_d  = '0;
        end
        S_STORE_WAIT: begin
          if (bus.MOC) begin
            state_d  = S_FETCH1;
            retire_d = 1'b1;
          end else if (wait_expired) begin
            state_d   = S_ERROR;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + TIMEOUT_W'(1);
          end
        end
        S_BEQ: begin
          if (bus.Cond) begin
            state_d = S_BEQ_TAKEN;
          end else begin
            state_d  = S_FETCH1;
            retire_d = 1'b1;
          end
        end
        S_BEQ_TAKEN: begin
          state_d  = S_FETCH1;
          retire_d = 1'b1;
        end
        S_LOAD: begin
          state_d = S_LOAD_WAIT;
          wait_d  = '0;
        end
        S_LOAD_WAIT: begin
          if (bus.MOC) begin
            state_d = S_LOAD_WB;
          end else if (wait_expired) begin
            state_d   = S_ERROR;
            bus_err_d = 1'b1;
          end else begin
            wait_d = wait_q + TIMEOUT_W'(1);
          end
        end
        S_LOAD_WB: begin
          state_d  = S_FETCH1;
          retire_d = 1'b1;
        end
        S_ILLEGAL: begin
          state_d   = S_FETCH1;
          illegal_d = 1'b1;
        end
        S_ERROR: state_d = S_ERROR;
        // Corrupted state register: park in ERROR rather than wander
        default: begin
          state_d   = S_ERROR;
          bus_err_d = 1'b1;
        end
      endcase
      if (retire_d) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously by Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH0;
      wait_q    <= '0;
      count_q   <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.State_Sel   = STATE_W'(state_q);
  assign bus.Retire      = retire_q;
  assign bus.Illegal_Op  = illegal_q;
  assign bus.Bus_Err     = bus_err_q;
  assign bus.Instr_Count = count_q;

endmodule

// File: tb/tb_ctrl_state_sequencer.sv
// tb/tb_ctrl_state_sequencer.sv - directed table-driven bench for ctrl_state_sequencer
module tb_ctrl_state_sequencer;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        moc   = 1'b0;
  logic        cond  = 1'b0;
  logic        stall = 1'b0;

  int passed  = 0;
  int total   = 0;
  int cur_vec = -1;
  int exp_cnt = 0;
  int exp_ill = 0;

  ctrl_state_sequencer_if #(.STATE_W(7), .CNT_W(16)) bus_a ();
  ctrl_state_sequencer_if #(.STATE_W(7), .CNT_W(2))  bus_b ();

  assign bus_a.Instruction = instr;
  assign bus_a.MOC         = moc;
  assign bus_a.Cond        = cond;
  assign bus_a.Stall       = stall;
  assign bus_b.Instruction = instr;
  assign bus_b.MOC         = moc;
  assign bus_b.Cond        = cond;
  assign bus_b.Stall       = stall;

  ctrl_state_sequencer #(.STATE_W(7), .TIMEOUT_W(4), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  ctrl_state_sequencer #(.STATE_W(7), .TIMEOUT_W(4), .CNT_W(2)) dut_w2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]       instr;
    logic              cond;
    int                n;
    logic [3:0][6:0]   seq;
    logic              retire;
    logic              illegal;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [31:0] i, input logic c, input int n,
                              input int s0, input int s1, input int s2, input int s3,
                              input logic r, input logic il);
    vec_t v;
    v.instr   = i;
    v.cond    = c;
    v.n       = n;
    v.seq[0]  = 7'(s0);
    v.seq[1]  = 7'(s1);
    v.seq[2]  = 7'(s2);
    v.seq[3]  = 7'(s3);
    v.retire  = r;
    v.illegal = il;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s [vec %0d]: got %0d, expected %0d", nm, cur_vec, act, exp);
  endtask

  task automatic chk_counts();
    chk("instr_count", int'(bus_a.Instr_Count), exp_cnt % 65536);
    chk("instr_count_w2", int'(bus_b.Instr_Count), exp_cnt % 4);
  endtask

  // From state 1: walk 2,3,4 with memory answering at once
  task automatic fetch(input logic [31:0] i);
    instr = i;
    moc   = 1'b1;
    stall = 1'b0;
    tick(); chk("fetch_2", int'(bus_a.State_Sel), 2);
    chk("retire_low_2", int'(bus_a.Retire), 0);
    tick(); chk("fetch_3", int'(bus_a.State_Sel), 3);
    tick(); chk("fetch_4", int'(bus_a.State_Sel), 4);
  endtask

  task automatic run_vec(input vec_t v);
    cond = v.cond;
    fetch(v.instr);
    if (v.retire)  exp_cnt++;
    if (v.illegal) exp_ill = 1;
    for (int k = 0; k < v.n; k++) begin
      tick();
      chk("exec_state", int'(bus_a.State_Sel), int'(v.seq[k]));
      chk("retire", int'(bus_a.Retire), (k == v.n - 1) ? int'(v.retire) : 0);
    end
    chk_counts();
    chk("illegal_op", int'(bus_a.Illegal_Op), exp_ill);
    chk("bus_err", int'(bus_a.Bus_Err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int guard;

    vecs[0]  = mk(32'h00851021, 1'b0, 2,   6,  1, 0, 0, 1'b1, 1'b0); // ADDU
    vecs[1]  = mk(32'h00851023, 1'b0, 2,  17,  1, 0, 0, 1'b1, 1'b0); // SUBU
    vecs[2]  = mk(32'h24420001, 1'b0, 2,  18,  1, 0, 0, 1'b1, 1'b0); // ADDIU
    vecs[3]  = mk(32'h0085102B, 1'b0, 2,  19,  1, 0, 0, 1'b1, 1'b0); // SLTU
    vecs[4]  = mk(32'h2C420001, 1'b0, 2,  20,  1, 0, 0, 1'b1, 1'b0); // SLTIU
    vecs[5]  = mk(32'h70851021, 1'b0, 2,  21,  1, 0, 0, 1'b1, 1'b0); // CLO
    vecs[6]  = mk(32'h70851020, 1'b0, 2,  22,  1, 0, 0, 1'b1, 1'b0); // CLZ
    vecs[7]  = mk(32'h00851024, 1'b0, 2,  23,  1, 0, 0, 1'b1, 1'b0); // AND
    vecs[8]  = mk(32'h30420001, 1'b0, 2,  24,  1, 0, 0, 1'b1, 1'b0); // ANDI
    vecs[9]  = mk(32'h00851025, 1'b0, 2,  25,  1, 0, 0, 1'b1, 1'b0); // OR
    vecs[10] = mk(32'h34420001, 1'b0, 2,  26,  1, 0, 0, 1'b1, 1'b0); // ORI
    vecs[11] = mk(32'hAC820004, 1'b0, 3,   7,  8, 1, 0, 1'b1, 1'b0); // SW
    vecs[12] = mk(32'hA0820004, 1'b0, 3,   7,  8, 1, 0, 1'b1, 1'b0); // SB
    vecs[13] = mk(32'h8C820004, 1'b0, 4,  13, 14, 15, 1, 1'b1, 1'b0); // LW
    vecs[14] = mk(32'h90820004, 1'b0, 4,  13, 14, 15, 1, 1'b1, 1'b0); // LBU
    vecs[15] = mk(32'h10850003, 1'b0, 2,  11,  1, 0, 0, 1'b1, 1'b0); // BEQ not taken
    vecs[16] = mk(32'h10850003, 1'b1, 3,  11, 12, 1, 0, 1'b1, 1'b0); // BEQ taken
    vecs[17] = mk(32'hFC000000, 1'b0, 2, 127,  1, 0, 0, 1'b0, 1'b1); // opcode 0x3F
    vecs[18] = mk(32'h00851021, 1'b0, 2,   6,  1, 0, 0, 1'b1, 1'b0); // fetch after illegal

    // Reset values
    tick();
    chk("reset_state", int'(bus_a.State_Sel), 0);
    chk("reset_retire", int'(bus_a.Retire), 0);
    chk("reset_illegal", int'(bus_a.Illegal_Op), 0);
    chk("reset_bus_err", int'(bus_a.Bus_Err), 0);
    chk_counts();
    Reset = 1'b0;
    tick();
    chk("first_fetch1", int'(bus_a.State_Sel), 1);
    chk("first_no_retire", int'(bus_a.Retire), 0);

    for (int i = 0; i < NVEC; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Load whose memory answers on the third cycle in 14
    cur_vec = 100;
    cond = 1'b0;
    fetch(32'h8C820004);
    tick(); chk("lw_13", int'(bus_a.State_Sel), 13);
    moc = 1'b0;
    tick(); chk("lw_14a", int'(bus_a.State_Sel), 14);
    tick(); chk("lw_14b", int'(bus_a.State_Sel), 14);
    tick(); chk("lw_14c", int'(bus_a.State_Sel), 14);
    moc = 1'b1;
    tick(); chk("lw_15", int'(bus_a.State_Sel), 15);
    tick(); chk("lw_1", int'(bus_a.State_Sel), 1);
    chk("lw_retire", int'(bus_a.Retire), 1);
    exp_cnt++;
    chk_counts();

    // Stall wins over MOC in store wait
    cur_vec = 101;
    fetch(32'hAC820004);
    tick(); chk("sw_7", int'(bus_a.State_Sel), 7);
    tick(); chk("sw_8", int'(bus_a.State_Sel), 8);
    stall = 1'b1;
    tick(); chk("sw_stall_8a", int'(bus_a.State_Sel), 8);
    chk("sw_stall_retire", int'(bus_a.Retire), 0);
    tick(); chk("sw_stall_8b", int'(bus_a.State_Sel), 8);
    chk_counts();
    stall = 1'b0;
    tick(); chk("sw_1", int'(bus_a.State_Sel), 1);
    chk("sw_retire", int'(bus_a.Retire), 1);
    exp_cnt++;
    chk_counts();

    // Stall in decode: the IR present on the unstalled cycle decides
    cur_vec = 102;
    fetch(32'h00851021);
    stall = 1'b1;
    instr = 32'h00851025;
    tick(); chk("dec_stall_4", int'(bus_a.State_Sel), 4);
    stall = 1'b0;
    instr = 32'h30420001;
    tick(); chk("dec_redecode", int'(bus_a.State_Sel), 24);
    tick(); chk("dec_1", int'(bus_a.State_Sel), 1);
    chk("dec_retire", int'(bus_a.Retire), 1);
    exp_cnt++;
    chk_counts();

    // Asynchronous reset in the middle of load wait
    cur_vec = 103;
    fetch(32'h8C820004);
    tick(); chk("rst_13", int'(bus_a.State_Sel), 13);
    moc = 1'b0;
    tick(); chk("rst_14", int'(bus_a.State_Sel), 14);
    #2 Reset = 1'b1;
    #1;
    exp_cnt = 0;
    exp_ill = 0;
    chk("rst_async_state", int'(bus_a.State_Sel), 0);
    chk("rst_illegal_clr", int'(bus_a.Illegal_Op), 0);
    chk("rst_bus_err", int'(bus_a.Bus_Err), 0);
    chk_counts();
    tick(); chk("rst_held", int'(bus_a.State_Sel), 0);
    Reset = 1'b0;
    tick(); chk("rst_fetch1", int'(bus_a.State_Sel), 1);

    // MOC never arrives during fetch wait
    cur_vec = 104;
    moc = 1'b0;
    tick(); chk("to_enter_2", int'(bus_a.State_Sel), 2);
    n = 1;
    guard = 0;
    while (int'(bus_a.State_Sel) == 2 && guard < 40) begin
      tick();
      guard++;
      if (int'(bus_a.State_Sel) == 2) n++;
    end
    chk("to_cycles_in_2", n, 16);
    chk("to_state_126", int'(bus_a.State_Sel), 126);
    chk("to_bus_err", int'(bus_a.Bus_Err), 1);
    moc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("to_parked", int'(bus_a.State_Sel), 126);
    end
    chk("to_bus_err_sticky", int'(bus_a.Bus_Err), 1);
    #2 Reset = 1'b1;
    #1;
    chk("to_rst_state", int'(bus_a.State_Sel), 0);
    chk("to_rst_bus_err", int'(bus_a.Bus_Err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
